ddram_bram_responder: RTL and testbench

//  Memory-side responder for the DDRAM Avalon-MM burst port that our cores drive as initiator.

---
 rtl/ddram_bram_responder.sv | 191 +++++++++++++++++++
 tb/tb_ddram_bram_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_bram_responder.sv
// Block-RAM backed responder for the DDRAM Avalon-MM burst port (2^AW x 64-bit words).
// Define DDRAM_STALL_EN to inject pseudo-random waitrequest stalls from a 16-bit LFSR.
module ddram_bram_responder #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DEPTH   = 4,
    parameter logic [3:0]  BASE_HI = 4'b0011
) (
    input  logic        DDRAM_CLK,
    input  logic        DDRAM_RESET_N,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    input  logic        DDRAM_RD,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    input  logic        DDRAM_WE,
    output logic        oob
);
    localparam int unsigned QW = $clog2(DEPTH);

    typedef struct packed {
        logic          win;
        logic [AW-1:0] idx;
        logic [7:0]    cnt;
    } rd_cmd_t;

    logic [63:0]   mem_q [0:(1<<AW)-1];
    rd_cmd_t       q_mem_q [0:DEPTH-1];
    logic [QW-1:0] wp_q, rp_q;
    logic [QW:0]   q_cnt_q, q_cnt_d;

    logic          rd_active_q, rd_active_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    rd_left_q, rd_left_d;
    logic          rd_win_q, rd_win_d;

    logic          wr_open_q, wr_open_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]    wr_left_q, wr_left_d;
    logic          wr_win_q, wr_win_d;

    logic [63:0]   dout_q;
    logic          dout_rdy_q;
    logic          oob_q, oob_d;

    logic          in_win_s, q_full_s, q_empty_s, rd_pending_s, busy_s, stall_s;
    logic          we_acc_s, rd_acc_s, push_s, pop_s;
    logic [7:0]    cnt_norm_s, wr_left_s;
    logic [AW-1:0] wr_idx_s;
    logic          wr_win_s;
    rd_cmd_t       head_s;
    logic          unused_addr_s;

    assign unused_addr_s = ^DDRAM_ADDR[24:AW];

`ifdef DDRAM_STALL_EN
    logic [15:0] lfsr_q;

    // Stall source: x^16+x^14+x^13+x^11+1 Fibonacci LFSR
    always_ff @(posedge DDRAM_CLK) begin
        if (!DDRAM_RESET_N) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
    assign stall_s = (lfsr_q[1:0] == 2'b00) & ~dout_rdy_q;
`else
    assign stall_s = 1'b0;
`endif

    assign in_win_s     = (DDRAM_ADDR[28:25] == BASE_HI);
    assign cnt_norm_s   = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    assign q_full_s     = (q_cnt_q == (QW+1)'(DEPTH));
    assign q_empty_s    = (q_cnt_q == (QW+1)'(0));
    assign rd_pending_s = ~q_empty_s | rd_active_q;
    // Writes are held off behind earlier reads so read data never reflects later writes
    assign busy_s       = q_full_s | (DDRAM_WE & rd_pending_s & ~wr_open_q) | stall_s;
    assign we_acc_s     = DDRAM_RESET_N & DDRAM_WE & ~busy_s;
    assign rd_acc_s     = DDRAM_RESET_N & DDRAM_RD & ~DDRAM_WE & ~wr_open_q & ~busy_s;
    assign push_s       = rd_acc_s;
    assign head_s       = q_mem_q[rp_q];

    assign wr_idx_s  = wr_open_q ? wr_idx_q  : DDRAM_ADDR[AW-1:0];
    assign wr_win_s  = wr_open_q ? wr_win_q  : in_win_s;
    assign wr_left_s = wr_open_q ? wr_left_q : cnt_norm_s;

    // Write-burst and sticky out-of-window next state
    always_comb begin
        wr_open_d = wr_open_q;
        wr_idx_d  = wr_idx_q;
        wr_left_d = wr_left_q;
        wr_win_d  = wr_win_q;
        oob_d     = oob_q | (rd_acc_s & ~in_win_s);
        if (we_acc_s) begin
            wr_open_d = (wr_left_s != 8'd1);
            wr_idx_d  = wr_idx_s + AW'(1);
            wr_left_d = wr_left_s - 8'd1;
            wr_win_d  = wr_win_s;
            oob_d     = oob_d | ~wr_win_s;
        end else begin
            wr_open_d = wr_open_q;
        end
    end

    // Read engine: pop the head on the last beat of the current burst so bursts stream gap-free
    always_comb begin
        rd_active_d = rd_active_q;
        rd_idx_d    = rd_idx_q;
        rd_left_d   = rd_left_q;
        rd_win_d    = rd_win_q;
        pop_s       = 1'b0;
        if (!q_empty_s && (!rd_active_q || rd_left_q == 8'd1)) begin
            pop_s       = 1'b1;
            rd_active_d = 1'b1;
            rd_idx_d    = head_s.idx;
            rd_left_d   = head_s.cnt;
            rd_win_d    = head_s.win;
        end else if (rd_active_q) begin
            rd_active_d = (rd_left_q != 8'd1);
            rd_idx_d    = rd_idx_q + AW'(1);
            rd_left_d   = rd_left_q - 8'd1;
        end else begin
            rd_active_d = 1'b0;
        end
    end

    // Queue occupancy next state
    always_comb begin
        q_cnt_d = q_cnt_q;
        if (push_s && !pop_s) begin
            q_cnt_d = q_cnt_q + (QW+1)'(1);
        end else if (pop_s && !push_s) begin
            q_cnt_d = q_cnt_q - (QW+1)'(1);
        end else begin
            q_cnt_d = q_cnt_q;
        end
    end

    // RAM write port and command queue storage, neither is cleared by reset
    always_ff @(posedge DDRAM_CLK) begin
        if (we_acc_s && wr_win_s) begin
            for (int b = 0; b < 8; b++) begin
                if (DDRAM_BE[b]) mem_q[wr_idx_s][b*8 +: 8] <= DDRAM_DIN[b*8 +: 8];
            end
        end
        if (push_s) q_mem_q[wp_q] <= '{win: in_win_s, idx: DDRAM_ADDR[AW-1:0], cnt: cnt_norm_s};
    end

    // Control state and registered read-data outputs
    always_ff @(posedge DDRAM_CLK) begin
        if (!DDRAM_RESET_N) begin
            wp_q        <= '0;
            rp_q        <= '0;
            q_cnt_q     <= '0;
            rd_active_q <= 1'b0;
            rd_idx_q    <= '0;
            rd_left_q   <= 8'd0;
            rd_win_q    <= 1'b0;
            wr_open_q   <= 1'b0;
            wr_idx_q    <= '0;
            wr_left_q   <= 8'd0;
            wr_win_q    <= 1'b0;
            oob_q       <= 1'b0;
            dout_q      <= 64'd0;
            dout_rdy_q  <= 1'b0;
        end else begin
            if (push_s) wp_q <= wp_q + QW'(1);
            if (pop_s)  rp_q <= rp_q + QW'(1);
            q_cnt_q     <= q_cnt_d;
            rd_active_q <= rd_active_d;
            rd_idx_q    <= rd_idx_d;
            rd_left_q   <= rd_left_d;
            rd_win_q    <= rd_win_d;
            wr_open_q   <= wr_open_d;
            wr_idx_q    <= wr_idx_d;
            wr_left_q   <= wr_left_d;
            wr_win_q    <= wr_win_d;
            oob_q       <= oob_d;
            dout_rdy_q  <= rd_active_q;
            if (rd_active_q) dout_q <= rd_win_q ? mem_q[rd_idx_q] : 64'd0;
        end
    end

    assign DDRAM_BUSY       = busy_s;
    assign DDRAM_DOUT       = dout_q;
    assign DDRAM_DOUT_READY = dout_rdy_q;
    assign oob              = oob_q;
endmodule

// File: tb/tb_ddram_bram_responder.sv
// Scoreboard bench for ddram_bram_responder: directed writes/reads, queued bursts, ordering, oob, reset.
module tb_ddram_bram_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [7:0]  burstcnt = 8'd0;
    logic [28:0] addr = 29'd0;
    logic [63:0] dout;
    logic        dout_ready;
    logic        rd = 1'b0;
    logic [63:0] din = 64'd0;
    logic [7:0]  be = 8'd0;
    logic        we = 1'b0;
    logic        oob;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   nxt_cyc = 0;
    bit   mon_en = 1'b1;

    ddram_bram_responder dut (
        .DDRAM_CLK(clk), .DDRAM_RESET_N(rst_n), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt),
        .DDRAM_ADDR(addr), .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(dout_ready), .DDRAM_RD(rd),
        .DDRAM_DIN(din), .DDRAM_BE(be), .DDRAM_WE(we), .oob(oob)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every beat is checked for data and for the edge it appeared on
    always @(negedge clk) begin
        if (mon_en && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got %h expected no beat (cycle %0d)", dout, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_data", dout, e.data);
                chk("beat_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic begin_burst(input int acc);
        if (nxt_cyc < acc + 2) nxt_cyc = acc + 2;
    endtask

    task automatic exp_beat(input logic [63:0] d);
        exp_q.push_back('{data: d, cyc: nxt_cyc});
        nxt_cyc++;
    endtask

    task automatic hold_until_accepted(output int acc, output int waits);
        bit b;
        waits = 0;
        acc = -1;
        for (int i = 0; i < 1000; i++) begin
            #1 b = busy;
            @(posedge clk);
            if (!b) begin
                #1 acc = cyc;
                return;
            end
            waits++;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got busy for %0d cycles expected acceptance", waits);
    endtask

    task automatic rd_cmd(input logic [28:0] a, input logic [7:0] c, output int acc, output int waits);
        @(negedge clk);
        addr = a;
        burstcnt = c;
        rd = 1'b1;
        hold_until_accepted(acc, waits);
        rd = 1'b0;
    endtask

    task automatic wr_beat(input bit first, input logic [28:0] a, input logic [7:0] c,
                           input logic [63:0] d, input logic [7:0] bmask, output int acc);
        int w;
        @(negedge clk);
        addr = first ? a : 29'h1FFF_FFFF;
        burstcnt = first ? c : 8'hFF;
        din = d;
        be = bmask;
        we = 1'b1;
        hold_until_accepted(acc, w);
        we = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int acc, waits, tot, accw, expw;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_ready", 64'(dout_ready), 64'd0);
            chk("idle_oob", 64'(oob), 64'd0);
        end

        // 2: byte-enabled single write over known contents
        wr_beat(1'b1, 29'h0600_0010, 8'd1, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, acc);
        wr_beat(1'b1, 29'h0600_0010, 8'd1, 64'h1122_3344_5566_7788, 8'h0F, acc);
        rd_cmd(29'h0600_0010, 8'd1, acc, waits);
        begin_burst(acc);
        exp_beat(64'hAAAA_AAAA_5566_7788);
        wait_drain();

        // 3: write burst wrapping the top of the RAM, then read back and read the wrapped words
        wr_beat(1'b1, 29'h0600_FFFE, 8'd4, 64'd1, 8'hFF, acc);
        for (int k = 2; k <= 4; k++) wr_beat(1'b0, 29'd0, 8'd0, 64'(k), 8'hFF, acc);
        rd_cmd(29'h0600_FFFE, 8'd4, acc, waits);
        begin_burst(acc);
        for (int k = 1; k <= 4; k++) exp_beat(64'(k));
        rd_cmd(29'h0600_0000, 8'd0, acc, waits);
        begin_burst(acc);
        exp_beat(64'd3);
        wait_drain();

        // 4: DEPTH queued cnt=2 reads stream contiguously, then oversubscribe to fill the queue
        wr_beat(1'b1, 29'h0600_0100, 8'd8, 64'h100, 8'hFF, acc);
        for (int k = 1; k < 8; k++) wr_beat(1'b0, 29'd0, 8'd0, 64'h100 + 64'(k), 8'hFF, acc);
        tot = 0;
        for (int j = 0; j < 4; j++) begin
            rd_cmd(29'h0600_0100 + 29'(2*j), 8'd2, acc, waits);
            tot += waits;
            begin_burst(acc);
            exp_beat(64'h100 + 64'(2*j));
            exp_beat(64'h101 + 64'(2*j));
        end
`ifndef DDRAM_STALL_EN
        chk("no_busy_below_full", 64'(tot), 64'd0);
`endif
        wait_drain();
        tot = 0;
        for (int j = 0; j < 8; j++) begin
            rd_cmd(29'h0600_0100, 8'd8, acc, waits);
            tot += waits;
            begin_burst(acc);
            for (int k = 0; k < 8; k++) exp_beat(64'h100 + 64'(k));
        end
        chk("busy_when_full", 64'(tot > 0), 64'd1);
        wait_drain();

        // 5: write behind an 8-beat read is held until the last read beat
        rd_cmd(29'h0600_0100, 8'd8, acc, waits);
        begin_burst(acc);
        for (int k = 0; k < 8; k++) exp_beat(64'h100 + 64'(k));
        expw = nxt_cyc;
        wr_beat(1'b1, 29'h0600_0103, 8'd1, 64'hDEAD_BEEF_0000_0001, 8'hFF, accw);
        chk("write_accept_edge", 64'(accw), 64'(expw));
        wait_drain();
        rd_cmd(29'h0600_0103, 8'd1, acc, waits);
        begin_burst(acc);
        exp_beat(64'hDEAD_BEEF_0000_0001);
        wait_drain();

        // 6: out-of-window read and write, then reset in the middle of a burst
        chk("oob_before", 64'(oob), 64'd0);
        rd_cmd(29'h0200_0010, 8'd1, acc, waits);
        begin_burst(acc);
        exp_beat(64'd0);
        wait_drain();
        chk("oob_after_read", 64'(oob), 64'd1);
        wr_beat(1'b1, 29'h0200_0010, 8'd1, 64'h5555_5555_5555_5555, 8'hFF, acc);
        rd_cmd(29'h0600_0010, 8'd1, acc, waits);
        begin_burst(acc);
        exp_beat(64'hAAAA_AAAA_5566_7788);
        wait_drain();

        mon_en = 1'b0;
        rd_cmd(29'h0600_0100, 8'd8, acc, waits);
        for (int i = 0; i < 20 && dout_ready !== 1'b1; i++) @(negedge clk);
        chk("burst_started", 64'(dout_ready), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(dout_ready), 64'd0);
        chk("rst_oob", 64'(oob), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dout", dout, 64'd0);
        rst_n = 1'b1;
        nxt_cyc = 0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_ready", 64'(dout_ready), 64'd0);
        rd_cmd(29'h0600_0010, 8'd1, acc, waits);
        begin_burst(acc);
        exp_beat(64'hAAAA_AAAA_5566_7788);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
